// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO write port between
// several byte-stream requesters; a grant ends on packet last or after MAXBURST bytes.
module uart_tx_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAXBURST = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int IW1 = IW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [7:0]    LAST_CNT = 8'(MAXBURST - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W   = IW1'(NREQ);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   idx;
  logic          acc;
  logic          rel;
  logic [IW-1:0] cur_inc;

  // Scan downwards so the lowest rotation offset from ptr is the one that sticks.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + IW1'(k);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    acc     = (state_q == XFER) & req_valid[cur_q] & ~fifo_full;
    rel     = acc & (req_last[cur_q] | (cnt_q == LAST_CNT));
    cur_inc = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          cur_d   = pick;
          cnt_d   = '0;
        end
      end
      default: begin
        if (acc) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (rel) begin
          state_d = IDLE;
          ptr_d   = cur_inc;
        end
      end
    endcase
  end

  // Handshakes are suppressed while RST is high so an abandoned grant never half-writes.
  always_comb begin
    busy      = (state_q == XFER);
    gnt       = busy ? (NREQ'(1) << cur_q) : '0;
    req_ready = (busy & ~fifo_full & ~RST) ? (NREQ'(1) << cur_q) : '0;
    fifo_wr   = acc & ~RST;
    fifo_wdat = busy ? req_data[{cur_q, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a cycle vector table, directed packet sequences and
// a randomized run scored against a queue-based packet model.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 2;
  localparam int MAXBURST = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_wdat;
  logic [1:0]  gnt;
  logic        busy;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_wdat(fifo_wdat), .gnt(gnt), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [15:0] data;
    logic [1:0]  last;
    logic        full;
    logic        e_wr;
    logic [7:0]  e_wdat;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [1:0]  e_ready;
  } vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } beat_t;

  vec_t       vecs[$];
  beat_t      q0[$];
  beat_t      q1[$];
  logic [7:0] wlog[$];
  logic [7:0] exp_order[$];

  int checks = 0;
  int errors = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_sent = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic rst, input logic [1:0] valid, input logic [15:0] data,
                        input logic [1:0] last, input logic full, input logic e_wr,
                        input logic [7:0] e_wdat, input logic [1:0] e_gnt, input logic e_busy,
                        input logic [1:0] e_ready);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.full = full;
    v.e_wr = e_wr; v.e_wdat = e_wdat; v.e_gnt = e_gnt; v.e_busy = e_busy; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    RST       = v.rst;
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    fifo_full = v.full;
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic pushBeat(input int i, input logic [7:0] b, input logic l);
    beat_t x;
    x.b = b;
    x.l = l;
    if (i == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    RST = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #3;
    checkOutput("reset.busy", 16'(busy), 16'h0);
    checkOutput("reset.gnt", 16'(gnt), 16'h0);
    checkOutput("reset.ready", 16'(req_ready), 16'h0);
    checkOutput("reset.wr", 16'(fifo_wr), 16'h0);
    checkOutput("reset.wdat", 16'(fifo_wdat), 16'h0);
    m_owner = -1;
    m_ptr   = 0;
    m_sent  = 0;
  endtask

  // Model: one owner at a time, rotation from the slot after the last released owner.
  task automatic modelStep(input int cyc);
    logic [1:0] e_gnt, e_ready;
    logic       e_wr, e_busy;
    logic [7:0] e_wdat;
    beat_t      h;
    int         i;
    e_gnt = '0; e_ready = '0; e_wr = 1'b0; e_busy = 1'b0; e_wdat = '0;
    if (m_owner >= 0) begin
      e_busy  = 1'b1;
      e_gnt   = 2'(1 << m_owner);
      e_wdat  = req_data[8*m_owner +: 8];
      e_wr    = req_valid[m_owner] & ~fifo_full;
      e_ready = fifo_full ? 2'b00 : e_gnt;
    end
    checkOutput($sformatf("cyc%0d.busy", cyc), 16'(busy), 16'(e_busy));
    checkOutput($sformatf("cyc%0d.gnt", cyc), 16'(gnt), 16'(e_gnt));
    checkOutput($sformatf("cyc%0d.ready", cyc), 16'(req_ready), 16'(e_ready));
    checkOutput($sformatf("cyc%0d.wr", cyc), 16'(fifo_wr), 16'(e_wr));
    checkOutput($sformatf("cyc%0d.wdat", cyc), 16'(fifo_wdat), 16'(e_wdat));
    if (fifo_wr) wlog.push_back(fifo_wdat);
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req_valid[i]) begin
          m_owner = i;
          m_sent  = 0;
        end
      end
    end else if (e_wr) begin
      h = qhead(m_owner);
      qpop(m_owner);
      m_sent++;
      if (h.l || m_sent == MAXBURST) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  task automatic runStream(input int max_cycles, input int valid_pct, input int full_pct,
                           input int stall_from, input int stall_len);
    int    cyc;
    beat_t h;
    cyc = 0;
    wlog.delete();
    while ((q0.size() > 0 || q1.size() > 0) && cyc < max_cycles) begin
      @(posedge CLK); #1;
      req_valid = '0; req_data = '0; req_last = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (qsize(i) > 0) begin
          h = qhead(i);
          req_data[8*i +: 8] = h.b;
          req_last[i]        = h.l;
          req_valid[i]       = ($urandom_range(99) < valid_pct) &&
                               !(i == 0 && cyc >= stall_from && cyc < stall_from + stall_len);
        end
      end
      fifo_full = ($urandom_range(99) < full_pct);
      #3;
      modelStep(cyc);
      cyc++;
    end
    checkOutput("stream.drained", 16'(q0.size() + q1.size()), 16'h0);
    @(posedge CLK); #1;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
  endtask

  task automatic compareOrder(input string name);
    checkOutput({name, ".len"}, 16'(wlog.size()), 16'(exp_order.size()));
    for (int i = 0; i < wlog.size() && i < exp_order.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", name, i), 16'(wlog[i]), 16'(exp_order[i]));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    int len;
    RST = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    doReset();

    // Single packet, backpressure mid-packet, then reset mid-packet and re-arbitration.
    addVec(0, 2'b01, 16'h0041, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b01, 16'h0041, 2'b00, 0, 1, 8'h41, 2'b01, 1, 2'b01);
    addVec(0, 2'b01, 16'h0042, 2'b00, 0, 1, 8'h42, 2'b01, 1, 2'b01);
    addVec(0, 2'b01, 16'h0043, 2'b01, 0, 1, 8'h43, 2'b01, 1, 2'b01);
    addVec(0, 2'b00, 16'h0000, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b01, 16'h0041, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b01, 16'h0041, 2'b00, 0, 1, 8'h41, 2'b01, 1, 2'b01);
    for (int i = 0; i < 4; i++)
      addVec(0, 2'b01, 16'h0042, 2'b00, 1, 0, 8'h42, 2'b01, 1, 2'b00);
    addVec(0, 2'b01, 16'h0042, 2'b00, 0, 1, 8'h42, 2'b01, 1, 2'b01);
    addVec(0, 2'b01, 16'h0043, 2'b01, 0, 1, 8'h43, 2'b01, 1, 2'b01);
    addVec(0, 2'b00, 16'h0000, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b01, 16'h0051, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b01, 16'h0051, 2'b00, 0, 1, 8'h51, 2'b01, 1, 2'b01);
    addVec(1, 2'b01, 16'h0052, 2'b00, 0, 0, 8'h52, 2'b01, 1, 2'b00);
    addVec(0, 2'b11, 16'hC160, 2'b11, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b11, 16'hC160, 2'b11, 0, 1, 8'h60, 2'b01, 1, 2'b01);
    addVec(0, 2'b10, 16'hC100, 2'b10, 0, 0, 8'h00, 2'b00, 0, 2'b00);
    addVec(0, 2'b10, 16'hC100, 2'b10, 0, 1, 8'hC1, 2'b10, 1, 2'b10);
    addVec(0, 2'b00, 16'h0000, 2'b00, 0, 0, 8'h00, 2'b00, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK); #1;
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("vec%0d.wr", i), 16'(fifo_wr), 16'(vecs[i].e_wr));
      checkOutput($sformatf("vec%0d.wdat", i), 16'(fifo_wdat), 16'(vecs[i].e_wdat));
      checkOutput($sformatf("vec%0d.gnt", i), 16'(gnt), 16'(vecs[i].e_gnt));
      checkOutput($sformatf("vec%0d.busy", i), 16'(busy), 16'(vecs[i].e_busy));
      checkOutput($sformatf("vec%0d.ready", i), 16'(req_ready), 16'(vecs[i].e_ready));
    end

    $display("[TB] rotation between two 2-byte streams");
    doReset();
    for (int p = 0; p < 2; p++) begin
      pushBeat(0, 8'hA0, 1'b0); pushBeat(0, 8'hA1, 1'b1);
      pushBeat(1, 8'hB0, 1'b0); pushBeat(1, 8'hB1, 1'b1);
    end
    runStream(100, 100, 0, 0, 0);
    exp_order = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
    compareOrder("rotation");

    $display("[TB] burst cut at MAXBURST");
    doReset();
    for (int b = 0; b < 10; b++) pushBeat(0, 8'(b), b == 9);
    pushBeat(1, 8'hF0, 1'b1);
    runStream(100, 100, 0, 0, 0);
    exp_order = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hF0, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    compareOrder("burstcut");

    $display("[TB] owner stalls mid-packet");
    doReset();
    for (int b = 0; b < 4; b++) pushBeat(0, 8'hE0 + 8'(b), b == 3);
    pushBeat(1, 8'hD0, 1'b1);
    runStream(100, 100, 0, 3, 5);
    exp_order = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hD0};
    compareOrder("stall");

    $display("[TB] randomized packets with random valid and backpressure");
    doReset();
    total = 0;
    for (int r = 0; r < NREQ; r++) begin
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          pushBeat(r, 8'($urandom), b == len - 1);
          total++;
        end
      end
    end
    runStream(3000, 70, 25, 0, 0);
    checkOutput("random.bytes", 16'(wlog.size()), 16'(total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the UART transmit path between several byte-stream requesters, such as the CPU console, debug monitor and trace. It sits in front of the UART's transmit FIFO and writes one byte per accepted handshake into the FIFO write port. The UART drains that FIFO through its `rd`/`rdempty` interface. Packets from different requesters are never interleaved, and a burst limit bounds how long one requester can hold the line.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, range 2..8.
- `MAXBURST`, default 64: maximum bytes per grant, range 1..255.

Ports:
- `CLK`  in  1: single clock; all logic is on the rising edge.
- `RST`  in  1: synchronous reset, active-high.
- `req_valid`  in  NREQ: bit i set means requester i presents a byte.
- `req_data`  in  8*NREQ: byte of requester i on bits [8i+7:8i].
- `req_last`  in  NREQ: the byte of requester i is the last of its packet.
- `req_ready`  out  NREQ: byte of requester i is accepted this cycle when `req_valid[i]` is also set.
- `fifo_full`  in  1: the UART TX FIFO cannot accept a write.
- `fifo_wr`  out  1: FIFO write strobe, one byte per cycle.
- `fifo_wdat`  out  8: FIFO write data.
- `gnt`  out  NREQ: one-hot current owner; all zero when idle.
- `busy`  out  1: a grant is active.

## Operation
- FSM has two states: IDLE and XFER.
- Registered state:
  - `cur`: owner index.
  - `ptr`: round-robin start index, `$clog2(NREQ)` bits.
  - `cnt`: bytes sent in the current grant, 8 bits.
- IDLE behaviour:
  - If any `req_valid` is set, select the first set bit searching `ptr`, `ptr+1`, … mod NREQ.
  - Load `cur` with that index, clear `cnt`, and go to XFER.
  - If no `req_valid` is set, stay in IDLE.
- XFER accept condition: `acc = req_valid[cur] & ~fifo_full`.
- Combinational outputs in XFER:
  - `req_ready[cur] = ~fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr = acc`.
  - `fifo_wdat = req_data[cur]`.
- On `acc`, `cnt` increments.
- Release condition: `acc & (req_last[cur] | cnt == MAXBURST-1)`.
  - On release: next state IDLE, `ptr <= (cur+1) mod NREQ`.
- A burst cut by `MAXBURST` without `last` re-arbitrates normally. The cut requester resumes its packet on its next grant; the data stream stays lossless.
- If `req_valid[cur]` drops mid-packet, the grant is held and nothing is written. There is no timeout.
- In IDLE, all `req_ready` bits are 0, `fifo_wr` is 0, and `fifo_wdat` is don't-care (drive 0).
- `gnt = busy ? (1 << cur) : 0`; `busy = (state == XFER)`.
- Reset values: IDLE, `ptr = 0`, `cur = 0`, `cnt = 0`.
  - Resulting outputs: `gnt = 0`, `busy = 0`, `req_ready = 0`, `fifo_wr = 0`, `fifo_wdat = 0`.
- Reset mid-packet abandons the grant. The remaining bytes are the requester's responsibility, and no partial write occurs in the reset cycle.

## Timing
- Request to grant:
  - A `req_valid` seen in IDLE at edge N gives `busy`/`gnt` from edge N+1.
  - The first byte can be written in that same cycle (N+1).
- Throughput is one byte per cycle while `req_valid[cur]` is set and `fifo_full` is low.
- `fifo_full` is sampled combinationally. The FIFO must assert `full` such that a write in the same cycle is never lost; it is the FIFO's registered full flag.
- Between packets there is exactly one IDLE cycle: release at edge M, IDLE during M..M+1, next grant at M+1.
- Simultaneous requests are granted strictly in rotation from `ptr`. The requester just released is last in priority for the next arbitration.
- `RST` overrides everything in the same edge.

## Test plan
1. **Single packet, requester 0, FIFO never full.** Drive 0x41, 0x42, 0x43 with `last` on 0x43.
   - `fifo_wr` is high 3 consecutive cycles with `fifo_wdat` 41, 42, 43.
   - `gnt = 01` for those 3 cycles, then IDLE.
2. **Rotation, NREQ=2.** Both requesters continuously hold 2-byte packets (0xA0/0xA1 and 0xB0/0xB1).
   - Write order: A0 A1, idle, B0 B1, idle, A0 A1…
   - `gnt` alternates 01/10.
3. **Backpressure.** Assert `fifo_full` for 4 cycles in the middle of a 3-byte packet.
   - `fifo_wr` and `req_ready` stay 0 during those 4 cycles.
   - No byte is duplicated or dropped; output is exactly 41 42 43.
4. **Burst cut, MAXBURST=4.** Requester 0 sends 10 bytes 0x00..0x09 while requester 1 sends 0xF0 (`last`).
   - Write order: 00–03, F0, 04–07, 08 09.
5. **Requester stall.** `req_valid[0]` drops for 5 cycles mid-packet while requester 1 is valid.
   - `gnt` stays 01 and no writes occur; the packet completes when `req_valid[0]` returns.
   - Requester 1 is granted only afterwards.
6. **Reset mid-packet.** Assert `RST` for one cycle during the 2nd byte.
   - Next cycle: `busy = 0`, `gnt = 0`, `fifo_wr = 0`, `ptr = 0`.
   - A new packet from requester 1 is then granted normally.
